// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime/mtimecmp, msip, req/ack register bus, level IRQs.
// Define CLINT_MTIME_WRITE_EN to make MTIME writable; otherwise MTIME is read-only.
module clint_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  input  logic        time_halt_i,
  output logic        irq_software_o,
  output logic        irq_timer_o
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  // Word offsets (addr[15:2]) of the mapped registers.
  localparam logic [13:0] OFF_MSIP    = 14'h0000;
  localparam logic [13:0] OFF_CMP_LO  = 14'h1000;
  localparam logic [13:0] OFF_CMP_HI  = 14'h1001;
  localparam logic [13:0] OFF_TIME_LO = 14'h2FFE;
  localparam logic [13:0] OFF_TIME_HI = 14'h2FFF;

  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          cap;
  logic          commit;
  logic          we_q;
  logic [13:0]   off_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   rd_mux;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic          irq_timer_q;
  logic          unused_addr;

  assign unused_addr = ^{addr_i[31:16], addr_i[1:0]};

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          cap     = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign commit = (state_q == S_ACK) && we_q;

  always_comb begin
    rd_mux = '0;
    case (addr_i[15:2])
      OFF_MSIP:    rd_mux = {31'b0, msip_q};
      OFF_CMP_LO:  rd_mux = mtimecmp_q[31:0];
      OFF_CMP_HI:  rd_mux = mtimecmp_q[63:32];
      OFF_TIME_LO: rd_mux = mtime_q[31:0];
      OFF_TIME_HI: rd_mux = mtime_q[63:32];
      default:     rd_mux = '0;
    endcase
  end

  // Read data lives only in the ACK cycle; any other cycle it is zero.
  assign rdata_d = cap ? rd_mux : '0;

  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (!time_halt_i) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    mtime_d    = mtime_q;
    if (commit) begin
      case (off_q)
        OFF_MSIP:   msip_d            = wdata_q[0];
        OFF_CMP_LO: mtimecmp_d[31:0]  = wdata_q;
        OFF_CMP_HI: mtimecmp_d[63:32] = wdata_q;
        default:    ;
      endcase
    end
`ifdef CLINT_MTIME_WRITE_EN
    // A bus write to either half swallows that cycle's tick.
    if (commit && (off_q == OFF_TIME_LO)) begin
      mtime_d[31:0] = wdata_q;
    end else if (commit && (off_q == OFF_TIME_HI)) begin
      mtime_d[63:32] = wdata_q;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
`else
    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      off_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      presc_q     <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      irq_timer_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cap) begin
        we_q    <= we_i;
        off_q   <= addr_i[15:2];
        wdata_q <= wdata_i;
      end
      rdata_q     <= rdata_d;
      presc_q     <= presc_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      irq_timer_q <= (mtime_q >= mtimecmp_q);
    end
  end

  assign ack_o          = (state_q == S_ACK);
  assign rdata_o        = rdata_q;
  assign irq_software_o = msip_q;
  assign irq_timer_o    = irq_timer_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (TICK_DIV 1 and 4) share one bus and halt input,
// checked against a cycle-count reference model plus constant vector tables.
module tb_clint_timer;

  localparam int unsigned DIV_B = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic [31:0] rdata1, rdata4;
  logic        ack1, ack4, sw1, sw4, ti1, ti4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clint_timer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rstn(rstn), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata1), .ack_o(ack1), .time_halt_i(halt),
    .irq_software_o(sw1), .irq_timer_o(ti1)
  );

  clint_timer #(.TICK_DIV(DIV_B)) dut4 (
    .clk(clk), .rstn(rstn), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata4), .ack_o(ack4), .time_halt_i(halt),
    .irq_software_o(sw4), .irq_timer_o(ti4)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: mtime = number of ticks, where a tick is every DIV-th unhalted edge.
  logic [63:0]     m_mt1 = '0, m_mt4 = '0, m_cmp = '1;
  logic            m_msip = 1'b0, m_irq1 = 1'b0, m_irq4 = 1'b0;
  logic [63:0]     s_mt1 = '0, s_mt4 = '0, s_cmp = '1;
  logic            s_msip = 1'b0;
  longint unsigned m_run = 0;
  logic            m_tick1, m_tick4, m_wr_mt;
  logic            m_wr_vld = 1'b0;
  logic [31:0]     m_wr_off = '0, m_wr_dat = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mt1 = '0; m_mt4 = '0; m_cmp = '1; m_msip = 1'b0;
      m_irq1 = 1'b0; m_irq4 = 1'b0; m_run = 0; m_wr_vld = 1'b0;
      s_mt1 = '0; s_mt4 = '0; s_cmp = '1; s_msip = 1'b0;
    end else begin
      s_mt1 = m_mt1; s_mt4 = m_mt4; s_cmp = m_cmp; s_msip = m_msip;
      m_irq1 = (m_mt1 >= m_cmp);
      m_irq4 = (m_mt4 >= m_cmp);
      m_tick1 = !halt;
      if (!halt) m_run = m_run + 1;
      m_tick4 = !halt && ((m_run % DIV_B) == 0);
      m_wr_mt = 1'b0;
      if (m_wr_vld) begin
        case (m_wr_off[15:0] & 16'hFFFC)
          16'h0000: m_msip = m_wr_dat[0];
          16'h4000: m_cmp[31:0] = m_wr_dat;
          16'h4004: m_cmp[63:32] = m_wr_dat;
`ifdef CLINT_MTIME_WRITE_EN
          16'hBFF8: begin m_mt1[31:0] = m_wr_dat; m_mt4[31:0] = m_wr_dat; m_wr_mt = 1'b1; end
          16'hBFFC: begin m_mt1[63:32] = m_wr_dat; m_mt4[63:32] = m_wr_dat; m_wr_mt = 1'b1; end
`endif
          default: ;
        endcase
        m_wr_vld = 1'b0;
      end
      if (!m_wr_mt) begin
        if (m_tick1) m_mt1 = m_mt1 + 1;
        if (m_tick4) m_mt4 = m_mt4 + 1;
      end
    end
  end

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [63:0] mt);
    case (a[15:0] & 16'hFFFC)
      16'h0000: return {31'b0, s_msip};
      16'h4000: return s_cmp[31:0];
      16'h4004: return s_cmp[63:32];
      16'hBFF8: return mt[31:0];
      16'hBFFC: return mt[63:32];
      default:  return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    check("irq_timer1", ti1, m_irq1);
    check("irq_timer4", ti4, m_irq4);
    check("irq_sw1", sw1, m_msip);
    check("irq_sw4", sw4, m_msip);
  end

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] r1, output logic [31:0] r4);
    int lat;
    lat = 0;
    r1 = '0;
    r4 = '0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (ack1) lat = i;
    end
    check("ack_latency", lat, 1);
    if (lat != 0) begin
      check("ack4", ack4, 1);
      r1 = rdata1;
      r4 = rdata4;
      if (!w) begin
        check("rdata1_model", r1, ref_read(a, s_mt1));
        check("rdata4_model", r4, ref_read(a, s_mt4));
      end else begin
        m_wr_off = a; m_wr_dat = d; m_wr_vld = 1'b1;
      end
    end
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", ack1, 0);
    check("rdata_idle_zero", rdata1, 0);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_sw;
  } vec_t;

  vec_t        tbl[13];
  logic [31:0] alist[7];
  logic [31:0] r1, r4, a1, a4, b1, b4, pre1;
  logic        rw;
  int          to;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0,          1'b1};
    tbl[1]  = '{1'b0, 32'h0000_0000, 32'h0,          32'h0000_0001, 1'b1};
    tbl[2]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0,          1'b0};
    tbl[3]  = '{1'b0, 32'h0000_0000, 32'h0,          32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b1, 32'h0000_4000, 32'h1234_5678, 32'h0,          1'b0};
    tbl[5]  = '{1'b0, 32'h0000_4000, 32'h0,          32'h1234_5678, 1'b0};
    tbl[6]  = '{1'b1, 32'h0000_4004, 32'hFFFF_FFFF, 32'h0,          1'b0};
    tbl[7]  = '{1'b0, 32'h0000_4004, 32'h0,          32'hFFFF_FFFF, 1'b0};
    tbl[8]  = '{1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0,          1'b0};
    tbl[9]  = '{1'b0, 32'h0000_1234, 32'h0,          32'h0000_0000, 1'b0};
    tbl[10] = '{1'b0, 32'h0000_0008, 32'h0,          32'h0000_0000, 1'b0};
    tbl[11] = '{1'b1, 32'h0001_4000, 32'hFFFF_FFFF, 32'h0,          1'b0};
    tbl[12] = '{1'b0, 32'h0000_4000, 32'h0,          32'hFFFF_FFFF, 1'b0};
    alist = '{32'h0, 32'h4000, 32'h4004, 32'hBFF8, 32'hBFFC, 32'h1234, 32'h0004};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack1", ack1, 0);      check("rst_ack4", ack4, 0);
    check("rst_rdata1", rdata1, 0);  check("rst_rdata4", rdata4, 0);
    check("rst_ti1", ti1, 0);        check("rst_sw1", sw1, 0);
    rstn = 1'b1;

    // Free-running count after reset release
    repeat (10) @(negedge clk);
    bus(1'b0, 32'hBFF8, 32'h0, r1, r4);
    check("mtime_after_10_ge", (r1 >= 32'd10), 1);
    check("mtime_after_10_le", (r1 <= 32'd13), 1);
    check("irq_timer_idle", ti1, 0);

    // Compare hit and clear
    bus(1'b1, 32'h4004, 32'h0, r1, r4);
    bus(1'b1, 32'h4000, 32'h20, r1, r4);
    to = 0;
    while (!ti1 && to < 100) begin @(negedge clk); to++; end
    check("irq_timer_rise_seen", (to < 100), 1);
    bus(1'b1, 32'h4000, 32'hFFFF_FFFF, r1, r4);
    check("irq_timer_at_commit", ti1, 1);
    @(posedge clk); #1;
    check("irq_timer_fall", ti1, 0);

    // Register map vectors
    for (int i = 0; i < 13; i++) begin
      bus(tbl[i].w, tbl[i].a, tbl[i].d, r1, r4);
      if (!tbl[i].w) check($sformatf("tbl%0d_rdata", i), r1, tbl[i].exp_rd);
      check($sformatf("tbl%0d_sw", i), sw1, tbl[i].exp_sw);
    end

    // MTIME write behaviour, done under halt so the values are exact
    @(negedge clk); halt = 1'b1;
    bus(1'b0, 32'hBFF8, 32'h0, pre1, r4);
`ifdef CLINT_MTIME_WRITE_EN
    bus(1'b1, 32'hBFF8, 32'hFFFF_FFFE, r1, r4);
    bus(1'b1, 32'hBFFC, 32'h0, r1, r4);
    bus(1'b0, 32'hBFF8, 32'h0, r1, r4);  check("mtime_wr_lo", r1, 32'hFFFF_FFFE);
    bus(1'b0, 32'hBFFC, 32'h0, r1, r4);  check("mtime_wr_hi", r1, 32'h0);
    @(negedge clk); halt = 1'b0;
    @(negedge clk); @(negedge clk); halt = 1'b1;
    bus(1'b0, 32'hBFF8, 32'h0, r1, r4);  check("mtime_wrap_lo", r1, 32'h0);
    bus(1'b0, 32'hBFFC, 32'h0, r1, r4);  check("mtime_wrap_hi", r1, 32'h1);
`else
    bus(1'b1, 32'hBFF8, 32'hFFFF_FFFE, r1, r4);
    bus(1'b1, 32'hBFFC, 32'h0, r1, r4);
    bus(1'b0, 32'hBFF8, 32'h0, r1, r4);  check("mtime_ro_lo", r1, pre1);
`endif

    // Prescaler and halt: 16 unhalted cycles, then 8 halted cycles
    bus(1'b0, 32'hBFF8, 32'h0, a1, a4);
    @(negedge clk); halt = 1'b0;
    repeat (16) @(negedge clk);
    halt = 1'b1;
    bus(1'b0, 32'hBFF8, 32'h0, b1, b4);
    check("div1_16_cycles", b1 - a1, 32'd16);
    check("div4_16_cycles", b4 - a4, 32'd4);
    repeat (8) @(negedge clk);
    bus(1'b0, 32'hBFF8, 32'h0, r1, r4);
    check("div1_halt_hold", r1, a1 + 32'd16);
    check("div4_halt_hold", r4, a4 + 32'd4);

    // Randomised traffic against the model
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); halt = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rw = 1'($urandom_range(0, 1));
      bus(rw, alist[$urandom_range(0, 6)], $urandom, r1, r4);
    end
    @(negedge clk); halt = 1'b0;

    // Reset asserted during an ACK cycle
    bus(1'b1, 32'h0000, 32'h1, r1, r4);
    bus(1'b1, 32'h4004, 32'h0, r1, r4);
    bus(1'b1, 32'h4000, 32'h0, r1, r4);
    @(posedge clk); #1;
    check("pre_rst_ti", ti1, 1);
    check("pre_rst_sw", sw1, 1);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h4004; wdata = 32'h0;
    @(posedge clk); #1;
    check("mid_ack", ack1, 1);
    rstn = 1'b0;
    #1;
    check("rst_in_ack_ack", ack1, 0);
    check("rst_in_ack_rdata", rdata1, 0);
    check("rst_in_ack_ti", ti1, 0);
    check("rst_in_ack_sw", sw1, 0);
    req = 1'b0;
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    bus(1'b0, 32'h0000, 32'h0, r1, r4);  check("post_rst_msip", r1, 32'h0);
    bus(1'b0, 32'h4000, 32'h0, r1, r4);  check("post_rst_cmp_lo", r1, 32'hFFFF_FFFF);
    bus(1'b0, 32'h4004, 32'h0, r1, r4);  check("post_rst_cmp_hi", r1, 32'hFFFF_FFFF);
    bus(1'b0, 32'hBFFC, 32'h0, r1, r4);  check("post_rst_mtime_hi", r1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
